// File: rtl/sbox_ram_arbiter.sv
// S-box table RAM arbiter: shares one single-port RAM between the EX-stage
// custom unit (priority, lockable) and a host table loader (starvation-guarded).
module sbox_ram_arbiter #(
  parameter int unsigned AddrWidth       = 8,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned HostStarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cu_req_i,
  input  logic                 cu_we_i,
  input  logic                 cu_lock_i,
  input  logic [AddrWidth-1:0] cu_addr_i,
  input  logic [DataWidth-1:0] cu_wdata_i,
  output logic                 cu_gnt_o,
  output logic                 cu_rvalid_o,
  output logic [DataWidth-1:0] cu_rdata_o,
  input  logic                 host_req_i,
  input  logic                 host_we_i,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic [DataWidth-1:0] host_wdata_i,
  output logic                 host_gnt_o,
  output logic                 host_rvalid_o,
  output logic [DataWidth-1:0] host_rdata_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  input  logic [DataWidth-1:0] ram_rdata_i,
  output logic                 owner_lock_o
);

  localparam logic [3:0] Limit = 4'(HostStarveLimit);

  typedef enum logic {
    ARB,
    CU_LOCK
  } state_e;

  state_e     state;
  logic [3:0] starve_cnt;
  logic       cu_pend;
  logic       host_pend;
  logic       locked;

  // Dropping cu_req in CU_LOCK releases the RAM in that same cycle.
  assign locked = (state == CU_LOCK) && cu_req_i;

  always_comb begin
    cu_gnt_o   = 1'b0;
    host_gnt_o = 1'b0;
    if (rst_ni) begin
      if (locked) begin
        cu_gnt_o = 1'b1;
      end else if (cu_req_i && host_req_i) begin
        if (starve_cnt == Limit) host_gnt_o = 1'b1;
        else                     cu_gnt_o   = 1'b1;
      end else if (cu_req_i) begin
        cu_gnt_o = 1'b1;
      end else if (host_req_i) begin
        host_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (cu_gnt_o) begin
      ram_req_o   = 1'b1;
      ram_we_o    = cu_we_i;
      ram_addr_o  = cu_addr_i;
      ram_wdata_o = cu_wdata_i;
    end else if (host_gnt_o) begin
      ram_req_o   = 1'b1;
      ram_we_o    = host_we_i;
      ram_addr_o  = host_addr_i;
      ram_wdata_o = host_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= ARB;
      starve_cnt <= '0;
      cu_pend    <= 1'b0;
      host_pend  <= 1'b0;
    end else begin
      cu_pend   <= cu_gnt_o && !cu_we_i;
      host_pend <= host_gnt_o && !host_we_i;
      if (host_gnt_o) begin
        starve_cnt <= '0;
      end else if (host_req_i && starve_cnt != Limit) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      unique case (state)
        ARB: begin
          if (cu_gnt_o && cu_lock_i) state <= CU_LOCK;
        end
        CU_LOCK: begin
          if (!cu_req_i || !cu_lock_i) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  assign cu_rvalid_o   = cu_pend;
  assign host_rvalid_o = host_pend;
  assign cu_rdata_o    = ram_rdata_i;
  assign host_rdata_o  = ram_rdata_i;
  assign owner_lock_o  = (state == CU_LOCK);

endmodule
